async_fifo_flags: RTL and testbench
===================================

Name: async_fifo_flags

Overview:
Parametrised dual-clock FIFO that moves WIDTH-bit words from the clk_wr domain to the clk_rd domain. It uses Gray-coded pointers and SYNC_STAGES-deep synchronisers. Compared with the basic async FIFO it adds registered full/empty, programmable almost_full/almost_empty, per-domain fill counts, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer blocks in independent clock domains.

Parameters:
DEPTH, 16, number of entries; power of 2, >= 4; AW = log2(DEPTH)
WIDTH, 8, data word width
SYNC_STAGES, 2, flops per pointer synchroniser; legal range 2..4
AF_THRESH, DEPTH-4, almost_full asserts when wr_count >= AF_THRESH; legal range 1..DEPTH-1
AE_THRESH, 4, almost_empty asserts when rd_count <= AE_THRESH; legal range 0..DEPTH-1
FWFT, 0, 0 = standard read (data one cycle after pop); 1 = head word shown on data_out whenever !empty

Ports:
clk_wr  in  1  write clock
rst_wr  in  1  write-domain reset
clk_rd  in  1  read clock
rst_rd  in  1  read-domain reset, asynchronous, active-high
wr  in  1  write request
data_in  in  WIDTH  write data
full  out  1  FIFO full (registered, clk_wr)
almost_full  out  1  wr_count >= AF_THRESH (registered)
wr_count  out  AW+1  write-side fill level, 0..DEPTH
overflow  out  1  sticky: write attempted while full
rd  in  1  read/pop request
data_out  out  WIDTH  read data
rd_valid  out  1  FWFT=0: data_out valid this cycle; FWFT=1: equals !empty
empty  out  1  FIFO empty (registered, clk_rd)
almost_empty  out  1  rd_count <= AE_THRESH (registered)
rd_count  out  AW+1  read-side fill level, 0..DEPTH
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Interface: reset rst_wr, asynchronous, active-high; clock clk_wr. rst_rd is asynchronous, active-high on clk_rd.
- Reset values:
  - clk_wr domain: full=0, almost_full=0, wr_count=0, overflow=0.
  - clk_rd domain: empty=1, almost_empty=1, rd_count=0, underflow=0, rd_valid=0, data_out=0.
  - All pointers and synchroniser flops are cleared.
- Reset usage: a system reset asserts rst_wr and rst_rd together. After single-side reset the flags are undefined until the other side is also reset; outputs in the reset domain still take their reset values.
- Pointers:
  - Binary and Gray pointers are each AW+1 bits and both registered; Gray is registered from bin_next ^ (bin_next>>1). No combinational Gray feeds a synchroniser.
  - Write pointer Gray passes through SYNC_STAGES flops on clk_rd. Read pointer Gray passes through SYNC_STAGES flops on clk_wr.
  - Pointers wrap naturally at 2*DEPTH.
- Write:
  - Accepted when wr && !full: mem[wr_bin[AW-1:0]] <= data_in and wr_bin increments.
  - wr && full: the write is dropped, pointer unchanged, overflow <= 1 and held until rst_wr.
- full:
  - Registered from wr_gray_next == {~rsync[AW:AW-1], rsync[AW-2:0]}, where rsync is the synchronised read Gray pointer.
  - Asserts on the same edge as the write that fills the FIFO.
  - Deasserts SYNC_STAGES to SYNC_STAGES+1 clk_wr edges after the freeing pop's pointer update.
- Read, FWFT=0:
  - Accepted when rd && !empty: data_out <= mem[rd_bin[AW-1:0]], rd_bin increments, rd_valid=1 the next cycle.
  - No accepted read: rd_valid=0 and data_out holds its last value; it is never driven to Z.
- Read, FWFT=1:
  - data_out = mem[rd_bin[AW-1:0]], valid whenever !empty.
  - rd && !empty pops; the next word appears after the pointer update.
- Read while empty: rd && empty has no pointer change, sets underflow (sticky until rst_rd), and rd_valid=0.
- empty:
  - Registered from rd_gray_next == wsync, where wsync is the synchronised write Gray pointer.
  - Asserts on the edge of the last pop.
  - Deasserts SYNC_STAGES to SYNC_STAGES+1 clk_rd edges after the write pointer update.
- Fill counts:
  - wr_count = wr_bin_next - gray2bin(rsync); rd_count = gray2bin(wsync) - rd_bin_next. Both use AW+1-bit modular subtraction and are registered.
  - Counts are pessimistic: wr_count may over-report and rd_count may under-report by in-flight synchroniser latency. They are never wrong in the unsafe direction.
- Simultaneous wr and rd on the same edges while neither full nor empty: both succeed and the counts converge after sync latency.
- Memory is not reset. Reads of unwritten entries are impossible because of the empty gating.

Test Plan:
1. DEPTH=16, clk_wr 100 MHz, clk_rd 37 MHz; reset both, write 16 words 0x00..0x0F -> full=1 the edge after the 16th write, wr_count=16, almost_full set from wr_count=12; 17th write dropped and overflow=1.
2. FWFT=0, drain all 16 words -> data_out sequence 0x00..0x0F, each with rd_valid=1 the cycle after the pop; empty=1 after the 16th pop; extra rd sets underflow=1 and data_out holds 0x0F.
3. FWFT=1, single write 0xA5 into empty FIFO -> empty drops within SYNC_STAGES+1 clk_rd edges with data_out=0xA5 before any rd; one rd -> empty=1.
4. Pointer wrap: 40 write/read pairs at random rates with occupancy kept below 16 -> in-order data, no overflow/underflow, counts stay within 0..16.
5. SYNC_STAGES=3, AE_THRESH=4: write 5 words -> almost_empty falls only once rd_count reaches 5; pop one -> almost_empty=1 again.
6. Assert rst_wr and rst_rd mid-stream with 9 words stored -> all flags and counts return to reset values, empty=1; next written word 0x3C is the first word read.

Source files
------------

// File: rtl/async_fifo_flags_if.sv
// async_fifo_flags_if: producer/consumer bundle of the dual-clock FIFO.
// master = producer+consumer side (drives wr/data_in/rd), slave = the FIFO.
interface async_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int CW    = 5
);
    logic             wr;
    logic [WIDTH-1:0] data_in;
    logic             full;
    logic             almost_full;
    logic [CW-1:0]    wr_count;
    logic             overflow;
    logic             rd;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    rd_count;
    logic             underflow;

    modport master (
        output wr, data_in, rd,
        input  full, almost_full, wr_count, overflow,
        input  data_out, rd_valid, empty, almost_empty,
        input  rd_count, underflow
    );

    modport slave (
        input  wr, data_in, rd,
        output full, almost_full, wr_count, overflow,
        output data_out, rd_valid, empty, almost_empty,
        output rd_count, underflow
    );
endinterface

// File: rtl/async_fifo_flags.sv
// async_fifo_flags: Gray-pointer dual-clock FIFO with registered flags,
// fill counts, sticky errors and optional FWFT. Ports: clk/rst per side + bus.
module async_fifo_flags #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = DEPTH - 4,
    parameter int AE_THRESH   = 4,
    parameter int FWFT        = 0
) (
    input  logic                clk_wr,
    input  logic                rst_wr,
    input  logic                clk_rd,
    input  logic                rst_rd,
    async_fifo_flags_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t AF_T = ptr_t'(AF_THRESH);
    localparam ptr_t AE_T = ptr_t'(AE_THRESH);

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [WIDTH-1:0] mem_q [DEPTH];

    // write domain
    ptr_t wr_bin_q, wr_bin_d;
    ptr_t wr_gray_q, wr_gray_d;
    ptr_t wr_cnt_q, wr_cnt_d;
    ptr_t rsync_q [SYNC_STAGES];
    ptr_t rsync;
    logic full_q, full_d;
    logic af_q, af_d;
    logic ovf_q, ovf_d;
    logic wr_en;

    // read domain
    ptr_t rd_bin_q, rd_bin_d;
    ptr_t rd_gray_q, rd_gray_d;
    ptr_t rd_cnt_q, rd_cnt_d;
    ptr_t wsync_q [SYNC_STAGES];
    ptr_t wsync;
    logic empty_q, empty_d;
    logic ae_q, ae_d;
    logic unf_q, unf_d;
    logic rd_en;

    always_comb begin
        rsync     = rsync_q[SYNC_STAGES-1];
        wr_en     = bus.wr && !full_q;
        wr_bin_d  = wr_bin_q + ptr_t'(wr_en);
        wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
        // full: write Gray equals read Gray with the top two bits inverted
        full_d    = (wr_gray_d == {~rsync[AW:AW-1], rsync[AW-2:0]});
        wr_cnt_d  = wr_bin_d - gray2bin(rsync);
        af_d      = (wr_cnt_d >= AF_T);
        ovf_d     = ovf_q | (bus.wr & full_q);
    end

    always_ff @(posedge clk_wr or posedge rst_wr) begin
        if (rst_wr) begin
            wr_bin_q  <= '0;
            wr_gray_q <= '0;
            wr_cnt_q  <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= '0;
            end
        end else begin
            wr_bin_q   <= wr_bin_d;
            wr_gray_q  <= wr_gray_d;
            wr_cnt_q   <= wr_cnt_d;
            full_q     <= full_d;
            af_q       <= af_d;
            ovf_q      <= ovf_d;
            rsync_q[0] <= rd_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rsync_q[i] <= rsync_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_wr) begin
        if (wr_en) begin
            mem_q[wr_bin_q[AW-1:0]] <= bus.data_in;
        end
    end

    always_comb begin
        wsync     = wsync_q[SYNC_STAGES-1];
        rd_en     = bus.rd && !empty_q;
        rd_bin_d  = rd_bin_q + ptr_t'(rd_en);
        rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
        empty_d   = (rd_gray_d == wsync);
        rd_cnt_d  = gray2bin(wsync) - rd_bin_d;
        ae_d      = (rd_cnt_d <= AE_T);
        unf_d     = unf_q | (bus.rd & empty_q);
    end

    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            rd_bin_q  <= '0;
            rd_gray_q <= '0;
            rd_cnt_q  <= '0;
            empty_q   <= 1'b1;
            ae_q      <= 1'b1;
            unf_q     <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= '0;
            end
        end else begin
            rd_bin_q   <= rd_bin_d;
            rd_gray_q  <= rd_gray_d;
            rd_cnt_q   <= rd_cnt_d;
            empty_q    <= empty_d;
            ae_q       <= ae_d;
            unf_q      <= unf_d;
            wsync_q[0] <= wr_gray_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                wsync_q[i] <= wsync_q[i-1];
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // head word is shown while not empty; forced to 0 otherwise so
            // never-written memory is not exposed
            assign bus.data_out = empty_q ? '0 : mem_q[rd_bin_q[AW-1:0]];
            assign bus.rd_valid = !empty_q;
        end else begin : g_std
            logic [WIDTH-1:0] dout_q;
            logic             rdv_q;

            always_ff @(posedge clk_rd or posedge rst_rd) begin
                if (rst_rd) begin
                    dout_q <= '0;
                    rdv_q  <= 1'b0;
                end else begin
                    rdv_q <= rd_en;
                    if (rd_en) begin
                        dout_q <= mem_q[rd_bin_q[AW-1:0]];
                    end
                end
            end

            assign bus.data_out = dout_q;
            assign bus.rd_valid = rdv_q;
        end
    endgenerate

    assign bus.full         = full_q;
    assign bus.almost_full  = af_q;
    assign bus.wr_count     = wr_cnt_q;
    assign bus.overflow     = ovf_q;
    assign bus.empty        = empty_q;
    assign bus.almost_empty = ae_q;
    assign bus.rd_count     = rd_cnt_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_async_fifo_flags.sv
// tb_async_fifo_flags: directed bench for async_fifo_flags.
// u0 standard read, u1 FWFT, u2 three-stage sync with AE_THRESH=4.
module tb_async_fifo_flags;
    logic clk_wr = 1'b0;
    logic clk_rd = 1'b0;
    logic rst_wr = 1'b1;
    logic rst_rd = 1'b1;

    int checks = 0;
    int errors = 0;

    always #50  clk_wr = ~clk_wr;
    always #135 clk_rd = ~clk_rd;

    async_fifo_flags_if #(.WIDTH(8), .CW(5)) if0 ();
    async_fifo_flags_if #(.WIDTH(8), .CW(5)) if1 ();
    async_fifo_flags_if #(.WIDTH(8), .CW(5)) if2 ();

    async_fifo_flags #(.DEPTH(16), .WIDTH(8), .SYNC_STAGES(2), .FWFT(0)) u0 (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .clk_rd(clk_rd), .rst_rd(rst_rd),
        .bus(if0.slave)
    );

    async_fifo_flags #(.DEPTH(16), .WIDTH(8), .SYNC_STAGES(2), .FWFT(1)) u1 (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .clk_rd(clk_rd), .rst_rd(rst_rd),
        .bus(if1.slave)
    );

    async_fifo_flags #(.DEPTH(16), .WIDTH(8), .SYNC_STAGES(3),
                       .AE_THRESH(4), .FWFT(0)) u2 (
        .clk_wr(clk_wr), .rst_wr(rst_wr),
        .clk_rd(clk_rd), .rst_rd(rst_rd),
        .bus(if2.slave)
    );

    task automatic do_reset();
        if0.wr = 0; if0.rd = 0; if0.data_in = '0;
        if1.wr = 0; if1.rd = 0; if1.data_in = '0;
        if2.wr = 0; if2.rd = 0; if2.data_in = '0;
        rst_wr = 1; rst_rd = 1;
        #700;
        rst_wr = 0; rst_rd = 0;
        repeat (3) @(posedge clk_rd);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (if0.full !== 1'b0 || if0.almost_full !== 1'b0 ||
            if0.wr_count !== 5'd0 || if0.overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_wr: full=%b af=%b cnt=%0d ovf=%b want 0 0 0 0",
                     if0.full, if0.almost_full, if0.wr_count, if0.overflow);
        end
        checks++;
        if (if0.empty !== 1'b1 || if0.almost_empty !== 1'b1 ||
            if0.rd_count !== 5'd0 || if0.underflow !== 1'b0 ||
            if0.rd_valid !== 1'b0 || if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_rd: e=%b ae=%b cnt=%0d unf=%b v=%b d=%h want 1 1 0 0 0 00",
                     if0.empty, if0.almost_empty, if0.rd_count, if0.underflow,
                     if0.rd_valid, if0.data_out);
        end
    endtask

    task automatic test_fill();
        @(posedge clk_wr); #1;
        for (int i = 0; i < 16; i++) begin
            if0.wr = 1; if0.data_in = 8'(i);
            @(posedge clk_wr); #1;
            checks++;
            if (if0.wr_count !== 5'(i + 1) || if0.almost_full !== (i + 1 >= 12) ||
                if0.full !== (i == 15)) begin
                errors++;
                $display("FAIL fill_%0d: cnt=%0d af=%b full=%b want %0d %b %b",
                         i, if0.wr_count, if0.almost_full, if0.full,
                         i + 1, (i + 1 >= 12), (i == 15));
            end
        end
        if0.data_in = 8'hFF;
        @(posedge clk_wr); #1;
        if0.wr = 0;
        checks++;
        if (if0.overflow !== 1'b1 || if0.wr_count !== 5'd16 || if0.full !== 1'b1) begin
            errors++;
            $display("FAIL overflow: ovf=%b cnt=%0d full=%b want 1 16 1",
                     if0.overflow, if0.wr_count, if0.full);
        end
    endtask

    task automatic test_drain();
        int n;
        n = 0;
        while (if0.rd_count !== 5'd16 && n < 20) begin
            @(posedge clk_rd); #1;
            n++;
        end
        checks++;
        if (if0.rd_count !== 5'd16 || if0.empty !== 1'b0) begin
            errors++;
            $display("FAIL drain_sync: rd_count=%0d empty=%b want 16 0",
                     if0.rd_count, if0.empty);
        end
        if0.rd = 1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk_rd); #1;
            checks++;
            if (if0.rd_valid !== 1'b1 || if0.data_out !== 8'(i) ||
                if0.rd_count !== 5'(15 - i) || if0.almost_empty !== (i >= 11) ||
                if0.empty !== (i == 15)) begin
                errors++;
                $display("FAIL pop_%0d: v=%b d=%h cnt=%0d ae=%b e=%b want 1 %h %0d %b %b",
                         i, if0.rd_valid, if0.data_out, if0.rd_count,
                         if0.almost_empty, if0.empty, 8'(i), 15 - i,
                         (i >= 11), (i == 15));
            end
        end
        @(posedge clk_rd); #1;
        if0.rd = 0;
        checks++;
        if (if0.underflow !== 1'b1 || if0.rd_valid !== 1'b0 || if0.data_out !== 8'h0F) begin
            errors++;
            $display("FAIL underflow: unf=%b v=%b d=%h want 1 0 0f",
                     if0.underflow, if0.rd_valid, if0.data_out);
        end
        n = 0;
        while (if0.wr_count !== 5'd0 && n < 20) begin
            @(posedge clk_wr); #1;
            n++;
        end
        checks++;
        if (if0.wr_count !== 5'd0 || if0.full !== 1'b0 ||
            if0.almost_full !== 1'b0 || if0.overflow !== 1'b1) begin
            errors++;
            $display("FAIL wr_release: cnt=%0d full=%b af=%b ovf=%b want 0 0 0 1",
                     if0.wr_count, if0.full, if0.almost_full, if0.overflow);
        end
    endtask

    task automatic test_fwft();
        int n;
        do_reset();
        checks++;
        if (if1.data_out !== 8'h00 || if1.rd_valid !== 1'b0 || if1.empty !== 1'b1) begin
            errors++;
            $display("FAIL fwft_idle: d=%h v=%b e=%b want 00 0 1",
                     if1.data_out, if1.rd_valid, if1.empty);
        end
        @(posedge clk_wr); #1;
        if1.wr = 1; if1.data_in = 8'hA5;
        @(posedge clk_wr); #1;
        if1.wr = 0;
        n = 0;
        while (if1.empty !== 1'b0 && n < 5) begin
            @(posedge clk_rd); #1;
            n++;
        end
        checks++;
        if (n > 3 || if1.data_out !== 8'hA5 || if1.rd_valid !== 1'b1 ||
            if1.rd_count !== 5'd1) begin
            errors++;
            $display("FAIL fwft_show: edges=%0d d=%h v=%b cnt=%0d want <=3 a5 1 1",
                     n, if1.data_out, if1.rd_valid, if1.rd_count);
        end
        if1.rd = 1;
        @(posedge clk_rd); #1;
        if1.rd = 0;
        checks++;
        if (if1.empty !== 1'b1 || if1.rd_valid !== 1'b0 || if1.rd_count !== 5'd0 ||
            if1.underflow !== 1'b0) begin
            errors++;
            $display("FAIL fwft_pop: e=%b v=%b cnt=%0d unf=%b want 1 0 0 0",
                     if1.empty, if1.rd_valid, if1.rd_count, if1.underflow);
        end
    endtask

    task automatic test_wrap();
        int wn;
        int rn;
        do_reset();
        wn = 0;
        rn = 0;
        fork
            begin
                for (int c = 0; c < 4000 && wn < 40; c++) begin
                    @(posedge clk_wr); #1;
                    if (if0.wr) wn++;
                    if0.wr = 0;
                    checks++;
                    if (if0.wr_count > 5'd16) begin
                        errors++;
                        $display("FAIL wrap_wcnt: wr_count=%0d want <=16", if0.wr_count);
                    end
                    if (wn < 40 && !if0.full && (wn - rn) < 14 &&
                        $urandom_range(0, 2) != 0) begin
                        if0.wr = 1;
                        if0.data_in = 8'(8'h80 + wn);
                    end
                end
            end
            begin
                for (int c = 0; c < 2000 && rn < 40; c++) begin
                    @(posedge clk_rd); #1;
                    if (if0.rd) begin
                        checks++;
                        if (if0.rd_valid !== 1'b1 || if0.data_out !== 8'(8'h80 + rn)) begin
                            errors++;
                            $display("FAIL wrap_data_%0d: v=%b d=%h want 1 %h",
                                     rn, if0.rd_valid, if0.data_out, 8'(8'h80 + rn));
                        end
                        rn++;
                    end
                    if0.rd = 0;
                    if (if0.rd_count > 5'd16) begin
                        errors++;
                        $display("FAIL wrap_rcnt: rd_count=%0d want <=16", if0.rd_count);
                    end
                    if (rn < 40 && !if0.empty && $urandom_range(0, 1) != 0) begin
                        if0.rd = 1;
                    end
                end
            end
        join
        if0.wr = 0;
        if0.rd = 0;
        checks++;
        if (wn != 40 || rn != 40 || if0.overflow !== 1'b0 || if0.underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: wn=%0d rn=%0d ovf=%b unf=%b want 40 40 0 0",
                     wn, rn, if0.overflow, if0.underflow);
        end
    endtask

    task automatic test_almost_empty();
        int n;
        do_reset();
        @(posedge clk_wr); #1;
        for (int i = 0; i < 5; i++) begin
            if2.wr = 1; if2.data_in = 8'(8'h50 + i);
            @(posedge clk_wr); #1;
        end
        if2.wr = 0;
        n = 0;
        while (if2.rd_count !== 5'd5 && n < 12) begin
            @(posedge clk_rd); #1;
            n++;
            if (if2.rd_count < 5'd5) begin
                checks++;
                if (if2.almost_empty !== 1'b1) begin
                    errors++;
                    $display("FAIL ae_low: rd_count=%0d ae=%b want 1",
                             if2.rd_count, if2.almost_empty);
                end
            end
        end
        checks++;
        if (if2.rd_count !== 5'd5 || if2.almost_empty !== 1'b0) begin
            errors++;
            $display("FAIL ae_five: rd_count=%0d ae=%b want 5 0",
                     if2.rd_count, if2.almost_empty);
        end
        if2.rd = 1;
        @(posedge clk_rd); #1;
        if2.rd = 0;
        checks++;
        if (if2.rd_count !== 5'd4 || if2.almost_empty !== 1'b1 ||
            if2.rd_valid !== 1'b1 || if2.data_out !== 8'h50) begin
            errors++;
            $display("FAIL ae_pop: cnt=%0d ae=%b v=%b d=%h want 4 1 1 50",
                     if2.rd_count, if2.almost_empty, if2.rd_valid, if2.data_out);
        end
    endtask

    task automatic test_midreset();
        int n;
        do_reset();
        @(posedge clk_wr); #1;
        for (int i = 0; i < 9; i++) begin
            if0.wr = 1; if0.data_in = 8'(8'h60 + i);
            @(posedge clk_wr); #1;
        end
        if0.wr = 0;
        n = 0;
        while (if0.rd_count !== 5'd9 && n < 12) begin
            @(posedge clk_rd); #1;
            n++;
        end
        checks++;
        if (if0.rd_count !== 5'd9 || if0.wr_count !== 5'd9) begin
            errors++;
            $display("FAIL mid_fill: rd_count=%0d wr_count=%0d want 9 9",
                     if0.rd_count, if0.wr_count);
        end
        rst_wr = 1; rst_rd = 1;
        #1;
        checks++;
        if (if0.full !== 1'b0 || if0.almost_full !== 1'b0 || if0.wr_count !== 5'd0 ||
            if0.overflow !== 1'b0 || if0.empty !== 1'b1 || if0.almost_empty !== 1'b1 ||
            if0.rd_count !== 5'd0 || if0.underflow !== 1'b0 || if0.rd_valid !== 1'b0 ||
            if0.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: f=%b af=%b wc=%0d o=%b e=%b ae=%b rc=%0d u=%b v=%b d=%h",
                     if0.full, if0.almost_full, if0.wr_count, if0.overflow,
                     if0.empty, if0.almost_empty, if0.rd_count, if0.underflow,
                     if0.rd_valid, if0.data_out);
        end
        #600;
        rst_wr = 0; rst_rd = 0;
        @(posedge clk_wr); #1;
        if0.wr = 1; if0.data_in = 8'h3C;
        @(posedge clk_wr); #1;
        if0.wr = 0;
        n = 0;
        while (if0.empty !== 1'b0 && n < 6) begin
            @(posedge clk_rd); #1;
            n++;
        end
        checks++;
        if (if0.empty !== 1'b0 || if0.rd_count !== 5'd1) begin
            errors++;
            $display("FAIL mid_refill: empty=%b rd_count=%0d want 0 1",
                     if0.empty, if0.rd_count);
        end
        if0.rd = 1;
        @(posedge clk_rd); #1;
        if0.rd = 0;
        checks++;
        if (if0.rd_valid !== 1'b1 || if0.data_out !== 8'h3C || if0.empty !== 1'b1) begin
            errors++;
            $display("FAIL mid_first: v=%b d=%h e=%b want 1 3c 1",
                     if0.rd_valid, if0.data_out, if0.empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_wrap();
        test_almost_empty();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
